// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - serial configuration chain loader with fabric enable gating
//
// Takes paired A/B configuration words from a host valid/ready stream and
// shifts them MSB-first onto two serial chains. fabric_en rises only after a
// complete load and drops again when the next load starts.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - begin a load (only acted on while idle)
//   s_dataA/B, s_valid  - host words for chain A/B and their valid strobe
//   s_ready             - loader takes a word this cycle (decoded from state)
//   chain_dataA/B       - serial chain data, valid while chain_en is high
//   chain_en            - chain shift enable
//   fabric_en           - fabric run enable, high only on a fully loaded config
//   busy                - load in progress
//   done                - one-cycle pulse at the end of a load
module cfg_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] s_dataA,
  input  logic [WORD_W-1:0] s_dataB,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              chain_dataA,
  output logic              chain_dataB,
  output logic              chain_en,
  output logic              fabric_en,
  output logic              busy,
  output logic              done
);

  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int WC_W      = $clog2(NWORDS + 1);
  localparam int BC_W      = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WC_W-1:0]   word_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [WORD_W-1:0] shA;
  logic [WORD_W-1:0] shB;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // bit_cnt counts the bits still to present, including the one currently on
  // the chain, so a value of 1 marks the final shift cycle of a word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  if (s_valid) state_nxt = SHIFT;
      SHIFT: if (bit_cnt == BC_W'(1))
               state_nxt = (word_cnt == WC_W'(NWORDS)) ? DONE : LOAD;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign s_ready = (state == LOAD);

  // The chain outputs are registered, so the bit for the first shift cycle is
  // loaded straight from the host word; shA/shB keep only the bits after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt    <= '0;
      bit_cnt     <= '0;
      shA         <= '0;
      shB         <= '0;
      chain_dataA <= 1'b0;
      chain_dataB <= 1'b0;
      chain_en    <= 1'b0;
      fabric_en   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          word_cnt <= '0;
          if (start) fabric_en <= 1'b0;
        end
        LOAD: begin
          if (s_valid) begin
            chain_dataA <= s_dataA[WORD_W-1];
            chain_dataB <= s_dataB[WORD_W-1];
            chain_en    <= 1'b1;
            shA         <= s_dataA << 1;
            shB         <= s_dataB << 1;
            bit_cnt     <= (word_cnt == WC_W'(NWORDS - 1)) ? BC_W'(LAST_BITS)
                                                           : BC_W'(WORD_W);
            word_cnt    <= word_cnt + WC_W'(1);
          end
        end
        SHIFT: begin
          if (bit_cnt == BC_W'(1)) begin
            chain_en    <= 1'b0;
            chain_dataA <= 1'b0;
            chain_dataB <= 1'b0;
          end else begin
            chain_dataA <= shA[WORD_W-1];
            chain_dataB <= shB[WORD_W-1];
            shA         <= shA << 1;
            shB         <= shB << 1;
            bit_cnt     <= bit_cnt - BC_W'(1);
          end
        end
        DONE: fabric_en <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// tb/tb_cfg_loader.sv - self-checking bench for cfg_loader
module tb_cfg_loader;

  localparam int CL = 20;
  localparam int W  = 8;
  localparam int NW = 3;
  localparam int LB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         s_valid = 1'b0;
  logic [W-1:0] s_dataA = '0;
  logic [W-1:0] s_dataB = '0;
  logic         s_ready, chain_dataA, chain_dataB, chain_en, fabric_en, busy, done;

  logic         start4 = 1'b0;
  logic         s_valid4 = 1'b1;
  logic [3:0]   s_data4A = '0;
  logic [3:0]   s_data4B = '0;
  logic         s_ready4, chain_data4A, chain_data4B, chain_en4, fabric_en4, busy4, done4;

  cfg_loader #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .s_dataA(s_dataA), .s_dataB(s_dataB),
    .s_valid(s_valid), .s_ready(s_ready), .chain_dataA(chain_dataA),
    .chain_dataB(chain_dataB), .chain_en(chain_en), .fabric_en(fabric_en),
    .busy(busy), .done(done)
  );

  cfg_loader #(.CHAIN_LEN(20), .WORD_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .s_dataA(s_data4A), .s_dataB(s_data4B),
    .s_valid(s_valid4), .s_ready(s_ready4), .chain_dataA(chain_data4A),
    .chain_dataB(chain_data4B), .chain_en(chain_en4), .fabric_en(fabric_en4),
    .busy(busy4), .done(done4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: a load is a list of bits queued per accepted word and
  // drained one per cycle; phase 0 idle, 1 awaiting word, 2 streaming, 3 done.
  int   cyc = 0;
  int   m_phase = 0;
  int   m_words = 0;
  bit   m_fabric = 1'b0;
  bit   qa[$];
  bit   qb[$];
  logic [W-1:0] wa[NW];
  logic [W-1:0] wb[NW];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_phase = 0; m_words = 0; m_fabric = 1'b0;
      qa.delete(); qb.delete();
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_words = 0; m_fabric = 1'b0; end
        1: if (s_valid) begin
             int n;
             n = (m_words == NW - 1) ? LB : W;
             for (int i = 0; i < n; i++) begin
               qa.push_back(s_dataA[W-1-i]);
               qb.push_back(s_dataB[W-1-i]);
             end
             m_words++;
             m_phase = 2;
           end
        2: begin
             void'(qa.pop_front());
             void'(qb.pop_front());
             if (qa.size() == 0) m_phase = (m_words == NW) ? 3 : 1;
           end
        default: begin m_phase = 0; m_fabric = 1'b1; end
      endcase
    end
  end

  // Host data follows the model's count of accepted words.
  always @(negedge clk) begin
    s_dataA = (m_words < NW) ? wa[m_words] : 8'h00;
    s_dataB = (m_words < NW) ? wb[m_words] : 8'h00;
  end

  bit check_on = 1'b0;
  bit capA[$];
  bit capB[$];
  int en_count = 0;
  bit done_seen = 1'b0;
  int done_cyc = -1;

  always @(negedge clk) begin
    if (check_on) begin
      bit e_en;
      e_en = (m_phase == 2);
      chk("s_ready",     s_ready,     (m_phase == 1));
      chk("chain_en",    chain_en,    e_en);
      chk("chain_dataA", chain_dataA, e_en ? qa[0] : 1'b0);
      chk("chain_dataB", chain_dataB, e_en ? qb[0] : 1'b0);
      chk("busy",        busy,        (m_phase != 0));
      chk("done",        done,        (m_phase == 3));
      chk("fabric_en",   fabric_en,   m_fabric);
      if (chain_en === 1'b1) begin
        capA.push_back(chain_dataA);
        capB.push_back(chain_dataB);
        en_count++;
      end
      if (done === 1'b1) begin done_seen = 1'b1; done_cyc = cyc; end
    end
  end

  // WORD_W=4 instance: one nibble per LOAD cycle, s_valid held high.
  logic [3:0] nibA[5] = '{4'hA, 4'h5, 4'h3, 4'hC, 4'hF};
  logic [3:0] nibB[5] = '{4'h0, 4'hF, 4'h8, 4'h1, 4'h5};
  int  w4 = 0;
  int  en4 = 0;
  int  done4_cyc = -1;
  logic [19:0] cap4A = '0;
  logic [19:0] cap4B = '0;
  always @(negedge clk) begin
    if (s_ready4 === 1'b1) begin
      s_data4A = (w4 < 5) ? nibA[w4] : 4'h0;
      s_data4B = (w4 < 5) ? nibB[w4] : 4'h0;
      w4++;
    end
    if (chain_en4 === 1'b1) begin
      if (en4 < 20) begin
        cap4A[19-en4] = chain_data4A;
        cap4B[19-en4] = chain_data4B;
      end
      en4++;
    end
    if (done4 === 1'b1) done4_cyc = cyc;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [19:0] pack(input bit q[$]);
    logic [19:0] v;
    v = '0;
    for (int k = 0; k < 20 && k < q.size(); k++) v[19-k] = q[k];
    return v;
  endfunction

  function automatic logic [19:0] expect_bits(input logic [W-1:0] w[NW]);
    logic [19:0] v;
    for (int k = 0; k < 20; k++) v[19-k] = w[k/W][W-1-(k%W)];
    return v;
  endfunction

  int fab_after_start = 0;

  task automatic run_load(input int stall_n, input bit rand_valid,
                          input bit start_noise, output int t0);
    int budget;
    int stall;
    capA.delete(); capB.delete();
    en_count = 0; done_seen = 1'b0; done_cyc = -1;
    s_valid = 1'b1;
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    fab_after_start = fabric_en;
    budget = 0; stall = 0;
    while (!done_seen && budget < 400) begin
      if (m_phase == 1 && m_words == 1 && stall < stall_n) begin
        s_valid = 1'b0; stall++;
      end else if (rand_valid) s_valid = ($urandom_range(0, 3) != 0);
      else s_valid = 1'b1;
      if (start_noise) start = ($urandom_range(0, 2) == 0);
      step();
      budget++;
    end
    start = 1'b0;
    if (!done_seen) chk("load_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t;
    logic [19:0] exp_a, exp_b;
    wa = '{8'hA5, 8'h3C, 8'hF0};
    wb = '{8'h0F, 8'h81, 8'h50};
    rst = 1'b1;
    repeat (3) step();
    check_on = 1'b1;
    chk("rst_chain_en", chain_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fabric", fabric_en, 1'b0);
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_dataA", chain_dataA, 1'b0);
    rst = 1'b0;
    step();

    // Continuous stream, documented words.
    run_load(0, 1'b0, 1'b0, t);
    chk("t1_done_time", done_cyc, t + 24);
    chk("t1_en_cycles", en_count, 20);
    chk("t1_bitsA", pack(capA), 20'b10100101_00111100_1111);
    chk("t1_bitsB", pack(capB), 20'b00001111_10000001_0101);
    chk("t1_model_bitsA", expect_bits(wa), 20'b10100101_00111100_1111);
    step();
    chk("t1_fabric_T25", fabric_en, 1'b1);
    chk("t1_fabric_cyc", cyc, t + 25);
    repeat (3) step();

    // Host stall of 5 cycles before word 1.
    run_load(5, 1'b0, 1'b0, t);
    chk("stall_done_time", done_cyc, t + 29);
    chk("stall_en_cycles", en_count, 20);
    chk("stall_bitsA", pack(capA), 20'b10100101_00111100_1111);
    chk("stall_bitsB", pack(capB), 20'b00001111_10000001_0101);
    repeat (2) step();

    // Reset while shifting word 1.
    capA.delete(); capB.delete(); done_seen = 1'b0;
    s_valid = 1'b1; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 100 && !(m_phase == 2 && m_words == 2); i++) step();
    chk("rst_mid_reached", (m_phase == 2 && m_words == 2), 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_chain_en", chain_en, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    repeat (10) step();
    chk("rst_mid_no_done", done_seen, 1'b0);
    chk("rst_mid_fabric", fabric_en, 1'b0);
    run_load(0, 1'b0, 1'b0, t);
    chk("after_rst_done_time", done_cyc, t + 24);
    chk("after_rst_bitsA", pack(capA), 20'b10100101_00111100_1111);
    repeat (3) step();

    // Restart with start pulses while busy.
    chk("restart_fabric_before", fabric_en, 1'b1);
    run_load(0, 1'b0, 1'b1, t);
    chk("restart_fabric_cleared", fab_after_start, 0);
    chk("restart_done_time", done_cyc, t + 24);
    chk("restart_en_cycles", en_count, 20);
    repeat (3) step();

    // Randomized words, valid gaps and start noise.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NW; i++) begin
        wa[i] = 8'($urandom);
        wb[i] = 8'($urandom);
      end
      exp_a = expect_bits(wa);
      exp_b = expect_bits(wb);
      run_load(0, 1'b1, 1'b1, t);
      chk("rand_en_cycles", en_count, 20);
      chk("rand_bitsA", pack(capA), exp_a);
      chk("rand_bitsB", pack(capB), exp_b);
      repeat ($urandom_range(1, 4)) step();
    end

    // WORD_W=4 instance.
    w4 = 0; en4 = 0; done4_cyc = -1;
    start4 = 1'b1; t = cyc; step(); start4 = 1'b0;
    for (int i = 0; i < 60 && done4_cyc < 0; i++) step();
    chk("w4_done_time", done4_cyc, t + 26);
    chk("w4_en_cycles", en4, 20);
    chk("w4_bitsA", cap4A, 20'b10100101_00111100_1111);
    chk("w4_bitsB", cap4B, 20'b00001111_10000001_0101);
    step();
    chk("w4_fabric", fabric_en4, 1'b1);

    check_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
